// File: rtl/hazard_scoreboard_ctrl_if.sv
// Issue-control bundle between the decode stage and the hazard scoreboard.
// master drives decode/writeback/squash/branch info; slave returns stall/flush/status.
interface hazard_scoreboard_ctrl_if;
  logic        id_valid;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        Two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic        sq_en;
  logic [3:0]  sq_dest;
  logic        exe_branch_taken;
  logic        hazard;
  logic        flush;
  logic        issue;
  logic [15:0] busy_map;
  logic        sb_err;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  modport master (
    output id_valid, src1, src2, Two_src,
    output id_wb_en, id_dest,
    output wb_en, wb_dest, sq_en, sq_dest,
    output exe_branch_taken,
`ifdef HAZARD_STATS_EN
    input  stall_cnt,
`endif
    input  hazard, flush, issue,
    input  busy_map, sb_err
  );

  modport slave (
    input  id_valid, src1, src2, Two_src,
    input  id_wb_en, id_dest,
    input  wb_en, wb_dest, sq_en, sq_dest,
    input  exe_branch_taken,
`ifdef HAZARD_STATS_EN
    output stall_cnt,
`endif
    output hazard, flush, issue,
    output busy_map, sb_err
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage issue controller: per-register pending-write scoreboard
// plus branch-flush FSM.
// Ports: clk, rst (async active-low), sb (slave modport): decode
// src/dest, writeback, squash, branch in; hazard/issue (comb),
// flush/busy_map/sb_err (registered) out.
// Optional: HAZARD_STATS_EN adds sb.stall_cnt, saturating count of
// hazard cycles.
module hazard_scoreboard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  hazard_scoreboard_ctrl_if.slave sb
);

  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [2:0] FL_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} st_t;

  st_t              st_q, st_d;
  logic [2:0]       fc_q, fc_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic [SW-1:0]    sum   [16];
  logic [15:0]      busy_q, busy_d;
  logic             err_q, err_d;
  logic             flush;
  logic             raw, full;
  logic             hazard, issue;
  logic             inc, dw, ds;

  assign raw = busy_q[sb.src1]
             | (sb.Two_src & busy_q[sb.src2]);
  assign full = sb.id_wb_en
              & (cnt_q[sb.id_dest] == MAXC);
  assign hazard = sb.id_valid & (raw | full) & ~flush;
  assign issue = sb.id_valid & ~hazard & ~flush;

  // Net change per register is in -2..+1; sum is wide
  // enough to hold it in two's complement so that the
  // MSB flags underflow and the next bit flags overflow.
  always_comb begin
    err_d  = err_q;
    busy_d = '0;
    inc    = 1'b0;
    dw     = 1'b0;
    ds     = 1'b0;
    for (int r = 0; r < 16; r++) begin
      inc = issue & sb.id_wb_en & (sb.id_dest == 4'(r));
      dw  = sb.wb_en & (sb.wb_dest == 4'(r));
      ds  = sb.sq_en & (sb.sq_dest == 4'(r));
      sum[r] = {2'b00, cnt_q[r]} + SW'(inc)
             - SW'(dw) - SW'(ds);
      if (sum[r][SW-1]) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else if (sum[r][SW-2]) begin
        cnt_d[r] = MAXC;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = sum[r][CNT_W-1:0];
      end
      busy_d[r] = |cnt_d[r];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= IDLE;
      fc_q <= '0;
    end else begin
      st_q <= st_d;
      fc_q <= fc_d;
    end
  end

  // A taken branch seen while flushing is itself
  // wrong-path, so FLUSH ignores exe_branch_taken.
  always_comb begin
    st_d = st_q;
    fc_d = fc_q;
    unique case (st_q)
      IDLE: begin
        if (sb.exe_branch_taken) begin
          st_d = FLUSH;
          fc_d = FL_LOAD;
        end
      end
      FLUSH: begin
        if (fc_q == 3'd0) st_d = IDLE;
        else              fc_d = fc_q - 3'd1;
      end
      default: begin
        st_d = IDLE;
        fc_d = '0;
      end
    endcase
  end

  always_comb begin
    flush = (st_q == FLUSH);
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_q <= '0;
    else if (hazard && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign sb.stall_cnt = stall_q;
`endif

  assign sb.hazard   = hazard;
  assign sb.issue    = issue;
  assign sb.flush    = flush;
  assign sb.busy_map = busy_q;
  assign sb.sb_err   = err_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: directed scenarios plus random
// traffic checked against a counter-array reference model.
module tb_hazard_scoreboard_ctrl;

  localparam int CNT_W = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_ctrl_if sb_if ();

  hazard_scoreboard_ctrl #(
    .CNT_W(CNT_W),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb(sb_if)
  );

  int checks = 0;
  int passed = 0;

  int m_cnt [16];
  int m_rem;
  bit m_err;
  int m_stall;
  logic exp_h, exp_i;

  function automatic logic m_flush();
    return m_rem > 0;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic logic m_hazard();
    logic raw, full;
    raw = (m_cnt[sb_if.src1] != 0) ||
          (sb_if.Two_src && m_cnt[sb_if.src2] != 0);
    full = sb_if.id_wb_en && m_cnt[sb_if.id_dest] == MAXC;
    return sb_if.id_valid && (raw || full) && !m_flush();
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_rem = 0;
    m_err = 0;
    m_stall = 0;
  endtask

  task automatic idle_inputs();
    sb_if.id_valid = 0;
    sb_if.src1 = 0;
    sb_if.src2 = 0;
    sb_if.Two_src = 0;
    sb_if.id_wb_en = 0;
    sb_if.id_dest = 0;
    sb_if.wb_en = 0;
    sb_if.wb_dest = 0;
    sb_if.sq_en = 0;
    sb_if.sq_dest = 0;
    sb_if.exe_branch_taken = 0;
  endtask

  // Advance one clock and the reference model with it.
  task automatic tick();
    int n;
    exp_h = m_hazard();
    exp_i = sb_if.id_valid && !exp_h && !m_flush();
    @(posedge clk);
    for (int r = 0; r < 16; r++) begin
      n = m_cnt[r];
      if (exp_i && sb_if.id_wb_en && sb_if.id_dest == r) n++;
      if (sb_if.wb_en && sb_if.wb_dest == r) n--;
      if (sb_if.sq_en && sb_if.sq_dest == r) n--;
      if (n < 0) begin n = 0; m_err = 1; end
      if (n > MAXC) begin n = MAXC; m_err = 1; end
      m_cnt[r] = n;
    end
    if (exp_h && m_stall < 65535) m_stall++;
    if (m_rem > 0) m_rem--;
    else if (sb_if.exe_branch_taken) m_rem = FLUSH_CYCLES;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    m_reset();
    #12;
    checks++;
    if (sb_if.flush !== 1'b0)
      $display("FAIL reset_flush got %b want 0", sb_if.flush);
    else passed++;
    checks++;
    if (sb_if.busy_map !== 16'h0)
      $display("FAIL reset_busy got %h want 0000", sb_if.busy_map);
    else passed++;
    checks++;
    if (sb_if.sb_err !== 1'b0)
      $display("FAIL reset_err got %b want 0", sb_if.sb_err);
    else passed++;
    checks++;
    if (sb_if.hazard !== 1'b0)
      $display("FAIL reset_hazard got %b want 0", sb_if.hazard);
    else passed++;
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_raw_stall();
    idle_inputs();
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 3;
    #1;
    checks++;
    if (sb_if.issue !== 1'b1)
      $display("FAIL raw_issue got %b want 1", sb_if.issue);
    else passed++;
    tick();
    sb_if.id_wb_en = 0;
    sb_if.src1 = 3;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (sb_if.hazard !== 1'b1 || sb_if.busy_map[3] !== 1'b1)
        $display("FAIL raw_stall got hz=%b busy3=%b want 1 1",
                 sb_if.hazard, sb_if.busy_map[3]);
      else passed++;
      tick();
    end
    sb_if.wb_en = 1;
    sb_if.wb_dest = 3;
    #1;
    checks++;
    if (sb_if.hazard !== 1'b1)
      $display("FAIL raw_nobypass got %b want 1", sb_if.hazard);
    else passed++;
    tick();
    sb_if.wb_en = 0;
    #1;
    checks++;
    if (sb_if.hazard !== 1'b0 || sb_if.busy_map[3] !== 1'b0)
      $display("FAIL raw_release got hz=%b busy3=%b want 0 0",
               sb_if.hazard, sb_if.busy_map[3]);
    else passed++;
    idle_inputs();
    tick();
  endtask

  task automatic test_two_src();
    idle_inputs();
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 5;
    tick();
    sb_if.id_wb_en = 0;
    sb_if.src1 = 1;
    sb_if.src2 = 5;
    sb_if.Two_src = 0;
    #1;
    checks++;
    if (sb_if.hazard !== 1'b0 || sb_if.issue !== 1'b1)
      $display("FAIL two_src_off got hz=%b iss=%b want 0 1",
               sb_if.hazard, sb_if.issue);
    else passed++;
    tick();
    sb_if.Two_src = 1;
    #1;
    checks++;
    if (sb_if.hazard !== 1'b1 || sb_if.issue !== 1'b0)
      $display("FAIL two_src_on got hz=%b iss=%b want 1 0",
               sb_if.hazard, sb_if.issue);
    else passed++;
    idle_inputs();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 5;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 2;
    for (int i = 0; i < MAXC; i++) begin
      #1;
      checks++;
      if (sb_if.issue !== 1'b1)
        $display("FAIL sat_fill%0d got %b want 1", i, sb_if.issue);
      else passed++;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (sb_if.hazard !== 1'b1 || sb_if.issue !== 1'b0)
        $display("FAIL sat_full got hz=%b iss=%b want 1 0",
                 sb_if.hazard, sb_if.issue);
      else passed++;
      if (i == 1) begin
        sb_if.wb_en = 1;
        sb_if.wb_dest = 2;
      end
      tick();
    end
    sb_if.wb_en = 0;
    #1;
    checks++;
    if (sb_if.hazard !== 1'b0 || sb_if.issue !== 1'b1)
      $display("FAIL sat_free got hz=%b iss=%b want 0 1",
               sb_if.hazard, sb_if.issue);
    else passed++;
    tick();
    idle_inputs();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 2;
    for (int i = 0; i < MAXC; i++) tick();
    idle_inputs();
    #1;
    checks++;
    if (sb_if.busy_map[2] !== 1'b0 || sb_if.sb_err !== 1'b0)
      $display("FAIL sat_drain got busy2=%b err=%b want 0 0",
               sb_if.busy_map[2], sb_if.sb_err);
    else passed++;
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 4;
    tick();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 4;
    tick();
    sb_if.wb_en = 0;
    checks++;
    if (sb_if.busy_map[4] !== 1'b1)
      $display("FAIL simul_incdec got busy4=%b want 1",
               sb_if.busy_map[4]);
    else passed++;
    tick();
    idle_inputs();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 4;
    sb_if.sq_en = 1;
    sb_if.sq_dest = 4;
    tick();
    idle_inputs();
    checks++;
    if (sb_if.busy_map[4] !== 1'b0 || sb_if.sb_err !== 1'b0)
      $display("FAIL simul_dbl_dec got busy4=%b err=%b want 0 0",
               sb_if.busy_map[4], sb_if.sb_err);
    else passed++;
  endtask

  task automatic test_flush();
    idle_inputs();
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 7;
    tick();
    idle_inputs();
    sb_if.exe_branch_taken = 1;
    tick();
    sb_if.exe_branch_taken = 1;
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 7;
    sb_if.src1 = 7;
    sb_if.sq_en = 1;
    sb_if.sq_dest = 7;
    #1;
    checks++;
    if (sb_if.flush !== 1'b1 || sb_if.issue !== 1'b0 ||
        sb_if.hazard !== 1'b0)
      $display("FAIL flush_c1 got fl=%b iss=%b hz=%b want 1 0 0",
               sb_if.flush, sb_if.issue, sb_if.hazard);
    else passed++;
    tick();
    sb_if.exe_branch_taken = 0;
    sb_if.sq_en = 0;
    sb_if.src1 = 0;
    #1;
    checks++;
    if (sb_if.flush !== 1'b1 || sb_if.issue !== 1'b0 ||
        sb_if.busy_map[7] !== 1'b0)
      $display("FAIL flush_c2 got fl=%b iss=%b busy7=%b want 1 0 0",
               sb_if.flush, sb_if.issue, sb_if.busy_map[7]);
    else passed++;
    tick();
    checks++;
    if (sb_if.flush !== 1'b0 || sb_if.issue !== 1'b1)
      $display("FAIL flush_end got fl=%b iss=%b want 0 1",
               sb_if.flush, sb_if.issue);
    else passed++;
    tick();
    idle_inputs();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 7;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_underflow_reset();
    idle_inputs();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 9;
    tick();
    idle_inputs();
    checks++;
    if (sb_if.sb_err !== 1'b1 || sb_if.busy_map[9] !== 1'b0)
      $display("FAIL underflow got err=%b busy9=%b want 1 0",
               sb_if.sb_err, sb_if.busy_map[9]);
    else passed++;
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 6;
    tick();
    idle_inputs();
    sb_if.exe_branch_taken = 1;
    tick();
    sb_if.exe_branch_taken = 0;
    checks++;
    if (sb_if.flush !== 1'b1 || sb_if.busy_map[6] !== 1'b1)
      $display("FAIL prereset got fl=%b busy6=%b want 1 1",
               sb_if.flush, sb_if.busy_map[6]);
    else passed++;
    #2;
    rst = 0;
    m_reset();
    #1;
    checks++;
    if (sb_if.flush !== 1'b0 || sb_if.busy_map !== 16'h0 ||
        sb_if.sb_err !== 1'b0)
      $display("FAIL async_reset got fl=%b busy=%h err=%b want 0 0 0",
               sb_if.flush, sb_if.busy_map, sb_if.sb_err);
    else passed++;
    #2;
    rst = 1;
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    idle_inputs();
    checks++;
    if (sb_if.stall_cnt !== 16'd0)
      $display("FAIL stats_reset got %0d want 0", sb_if.stall_cnt);
    else passed++;
    sb_if.id_valid = 1;
    sb_if.id_wb_en = 1;
    sb_if.id_dest = 1;
    tick();
    sb_if.id_wb_en = 0;
    sb_if.src1 = 1;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (sb_if.stall_cnt !== 16'd10)
      $display("FAIL stats_10 got %0d want 10", sb_if.stall_cnt);
    else passed++;
    idle_inputs();
    sb_if.wb_en = 1;
    sb_if.wb_dest = 1;
    tick();
    idle_inputs();
    tick();
  endtask
`endif

  task automatic test_random();
    logic [3:0] d;
    idle_inputs();
    rst = 0;
    m_reset();
    #3;
    rst = 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      sb_if.id_valid = ($urandom_range(0, 3) != 0);
      sb_if.src1 = 4'($urandom_range(0, 7));
      sb_if.src2 = 4'($urandom_range(0, 7));
      sb_if.Two_src = 1'($urandom_range(0, 1));
      sb_if.id_wb_en = ($urandom_range(0, 3) != 0);
      sb_if.id_dest = 4'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 7));
      sb_if.wb_dest = d;
      sb_if.wb_en = (m_cnt[d] > 0 && $urandom_range(0, 2) != 0) ||
                    ($urandom_range(0, 40) == 0);
      d = 4'($urandom_range(0, 7));
      sb_if.sq_dest = d;
      sb_if.sq_en = (m_cnt[d] > 0 && $urandom_range(0, 5) == 0);
      sb_if.exe_branch_taken = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (sb_if.hazard !== m_hazard() ||
          sb_if.issue !== (sb_if.id_valid && !m_hazard() &&
                           !m_flush()))
        $display("FAIL rnd_comb c%0d got hz=%b iss=%b want %b %b",
                 c, sb_if.hazard, sb_if.issue, m_hazard(),
                 sb_if.id_valid && !m_hazard() && !m_flush());
      else passed++;
      tick();
      checks++;
      if (sb_if.busy_map !== m_busy() ||
          sb_if.flush !== m_flush() || sb_if.sb_err !== m_err)
        $display("FAIL rnd_reg c%0d got b=%h f=%b e=%b want %h %b %b",
                 c, sb_if.busy_map, sb_if.flush, sb_if.sb_err,
                 m_busy(), m_flush(), m_err);
      else passed++;
`ifdef HAZARD_STATS_EN
      checks++;
      if (sb_if.stall_cnt !== 16'(m_stall))
        $display("FAIL rnd_stall c%0d got %0d want %0d",
                 c, sb_if.stall_cnt, m_stall);
      else passed++;
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_two_src();
    test_saturation();
    test_simultaneous();
    test_flush();
    test_underflow_reset();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Issue controller for the ARM pipeline decode stage. It generates the `hazard` stall consumed by the ID stage and the `flush` consumed by the ID/EXE stage register.
- Tracks in-flight register writes with per-register pending counters: incremented at issue from ID, decremented at writeback or squash.
- A branch-flush FSM squashes wrong-path instructions after a taken branch in EXE.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter. Max in-flight writes per register = 2^CNT_W-1.
- FLUSH_CYCLES, 2, cycles `flush` stays high after a taken branch. Range 1..7.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- id_valid  input  1  ID stage holds a valid decoded instruction.
- src1  input  4  first source register (Rn).
- src2  input  4  second source register (Rm/Rd for store).
- Two_src  input  1  src2 is read by this instruction.
- id_wb_en  input  1  instruction writes a register.
- id_dest  input  4  destination register.
- wb_en  input  1  writeback retires a register write this cycle.
- wb_dest  input  4  register retired by writeback.
- sq_en  input  1  an instruction with WB_EN set was squashed in ID/EXE reg this cycle.
- sq_dest  input  4  destination of the squashed instruction.
- exe_branch_taken  input  1  EXE resolved a taken branch.
- hazard  output  1  stall IF/ID; combinational.
- flush  output  1  squash ID/EXE and IF/ID; registered.
- issue  output  1  instruction accepted this cycle; combinational.
- busy_map  output  16  bit i = (counter[i] != 0); registered.
- sb_err  output  1  sticky underflow/overflow error; registered.

Behaviour:
- Reset (rst=0, async): all counters 0, busy_map=0, flush=0, FSM=IDLE, sb_err=0.
- RAW check, combinational: raw = busy[src1] | (Two_src & busy[src2]).
- WAW-capacity check: full = id_wb_en & (counter[id_dest] == max).
- hazard = id_valid & (raw | full) & !flush.
- issue = id_valid & !hazard & !flush.
- Counter update for register r, computed each cycle:
  - +1 if issue & id_wb_en & id_dest==r.
  - -1 if wb_en & wb_dest==r.
  - -1 if sq_en & sq_dest==r.
  - Net range -2..+1 applied in a single update. Simultaneous inc and dec on the same register → net 0.
- Underflow (net result <0): clamp to 0 and set sb_err.
- Overflow cannot occur because of the full check. A net +1 at max still clamps and sets sb_err.
- busy_map reflects the post-update counters one cycle later. No bypass: a writeback in cycle N releases a stall in cycle N+1.
- Flush FSM, states IDLE and FLUSH, with cnt[2:0]:
  - IDLE → FLUSH when exe_branch_taken. Load cnt=FLUSH_CYCLES-1; flush=1 from the next cycle.
  - FLUSH: flush=1. Decrement cnt; at cnt==0 → IDLE.
  - exe_branch_taken while in FLUSH is ignored, because the branch is itself on the wrong path.
- During flush, issue=0 and hazard=0, so no counter increments occur. Decrements continue.
- Reset mid-flush or with pending counters returns everything to the reset state immediately.
- sb_err clears only on reset.

Optional Feature:
- HAZARD_STATS_EN
  - Defined: add output stall_cnt[15:0]. It increments each cycle hazard=1, saturates at 16'hFFFF, and resets to 0.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- RAW stall: issue id_dest=3 with wb_en=0, then src1=3 → hazard=1 each cycle. Pulse wb_en with wb_dest=3 → hazard=0 the next cycle; busy_map[3] goes 1→0.
- Two_src gating: busy[5]=1, src1=1, src2=5. With Two_src=0 → hazard=0, issue=1. With Two_src=1 → hazard=1.
- Counter saturation (CNT_W=2): three issues to R2 → counter=3. A fourth with id_wb_en, id_dest=2 → hazard=1 until a writeback frees a slot.
- Simultaneous events: counter[4]=1. Same cycle: issue id_dest=4, wb_en with wb_dest=4 → counter stays 1. Next, wb_en and sq_en both to R4 at counter=2 → 0, sb_err=0.
- Flush: exe_branch_taken for 1 cycle → flush=1 for exactly 2 cycles, issue=0 throughout. A second exe_branch_taken during FLUSH does not extend it. sq_en to R7 clears busy_map[7].
- Underflow/reset: wb_en to R9 at counter 0 → counter stays 0, sb_err=1. Assert rst=0 mid-flush → flush, busy_map and sb_err go to 0 asynchronously. With HAZARD_STATS_EN, 10 stall cycles → stall_cnt=10.
